// File: rtl/ooo_pkg.sv
// ooo_pkg: shared widths, opcode constants and renamed-slot bundle type for the rename stage
package ooo_pkg;
  localparam int ARCH_W = 5;
  localparam int PREG_W = 6;
  localparam int NUM_PREG = 64;
  localparam int NUM_ARCH = 32;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  typedef logic [PREG_W-1:0] preg_t;
  typedef struct packed {
    preg_t prs1;
    preg_t prs2;
    preg_t prd;
    preg_t old_prd;
    logic [31:0] imm;
    logic [2:0] alu_op;
    logic [6:0] opcode;
    logic valid;
  } ren_slot_t;
  function automatic logic needs_alloc(input logic valid, input logic [ARCH_W-1:0] rd, input logic [6:0] opcode);
    return valid && rd != '0 && opcode != OP_STORE;
  endfunction
endpackage

// File: rtl/rename_free_list.sv
// rename_free_list: 64-entry circular free list of physical regs, 2 pop / 2 push ports; optional bitmap under RENAME_FREE_POOL_EN
module rename_free_list
  import ooo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pop_1,
  input  logic              pop_2,
  input  logic              free_valid_1,
  input  logic [PREG_W-1:0] free_preg_1,
  input  logic              free_valid_2,
  input  logic [PREG_W-1:0] free_preg_2,
  output logic [PREG_W-1:0] preg_1,
  output logic [PREG_W-1:0] preg_2,
  output logic [6:0]        count
`ifdef RENAME_FREE_POOL_EN
  ,
  output logic [NUM_PREG-1:0] free_pool
`endif
);
  preg_t mem [NUM_PREG];
  logic [PREG_W-1:0] head, tail;
  logic push_1, push_2, ovf;
  logic [1:0] n_pop, n_push;
  // head entries for slot-ordered pops; frees to preg 0 and pushes into a full list are dropped
  always_comb begin
    preg_1 = mem[head];
    preg_2 = mem[head + PREG_W'(pop_1)];
    push_1 = free_valid_1 && free_preg_1 != '0 && count != 7'(NUM_PREG);
    push_2 = free_valid_2 && free_preg_2 != '0 && count + 7'(push_1) < 7'(NUM_PREG);
    ovf = (free_valid_1 && free_preg_1 != '0 && !push_1) || (free_valid_2 && free_preg_2 != '0 && !push_2);
    n_pop = 2'(pop_1) + 2'(pop_2);
    n_push = 2'(push_1) + 2'(push_2);
  end
  // FIFO state: pops read the pre-edge head, so a preg freed this cycle cannot be reissued until later
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PREG; i++) mem[i] <= (i < NUM_ARCH) ? PREG_W'(i + NUM_ARCH) : '0;
      head <= '0;
      tail <= PREG_W'(NUM_ARCH);
      count <= 7'(NUM_ARCH);
    end else begin
      if (push_1) mem[tail] <= free_preg_1;
      if (push_2) mem[tail + PREG_W'(push_1)] <= free_preg_2;
      head <= head + PREG_W'(n_pop);
      tail <= tail + PREG_W'(n_push);
      count <= count + 7'(n_push) - 7'(n_pop);
    end
  end
  // a free arriving at a full list means the commit side double-freed a register
  overflow_chk: assert property (@(posedge clk) disable iff (rst) !ovf);
`ifdef RENAME_FREE_POOL_EN
  logic [NUM_PREG-1:0] pool_next;
  // bitmap mirrors list membership; preg 0 is never free
  always_comb begin
    pool_next = free_pool;
    if (pop_1) pool_next[preg_1] = 1'b0;
    if (pop_2) pool_next[preg_2] = 1'b0;
    if (push_1) pool_next[free_preg_1] = 1'b1;
    if (push_2) pool_next[free_preg_2] = 1'b1;
    pool_next[0] = 1'b0;
  end
  // bitmap register updates on the same edge as the list
  always_ff @(posedge clk) begin
    free_pool <= rst ? {{NUM_ARCH{1'b1}}, {NUM_ARCH{1'b0}}} : pool_next;
  end
`endif
endmodule

// File: rtl/rename_stage.sv
// rename_stage: 2-wide register rename with RAT, intra-bundle bypass and registered outputs; RENAME_FREE_POOL_EN adds free_pool bitmap output
module rename_stage
  import ooo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ARCH_W-1:0] rs1_1,
  input  logic [ARCH_W-1:0] rs2_1,
  input  logic [ARCH_W-1:0] rd_1,
  input  logic [31:0]       imm_1,
  input  logic [2:0]        alu_op_1,
  input  logic [6:0]        opcode_1,
  input  logic              valid_1,
  input  logic [ARCH_W-1:0] rs1_2,
  input  logic [ARCH_W-1:0] rs2_2,
  input  logic [ARCH_W-1:0] rd_2,
  input  logic [31:0]       imm_2,
  input  logic [2:0]        alu_op_2,
  input  logic [6:0]        opcode_2,
  input  logic              valid_2,
  input  logic              rs_full,
  output logic              out_valid,
  output logic [PREG_W-1:0] prs1_o_1,
  output logic [PREG_W-1:0] prs2_o_1,
  output logic [PREG_W-1:0] prd_o_1,
  output logic [PREG_W-1:0] old_prd_o_1,
  output logic [31:0]       imm_o_1,
  output logic [2:0]        alu_op_o_1,
  output logic [6:0]        opcode_o_1,
  output logic              valid_o_1,
  output logic [PREG_W-1:0] prs1_o_2,
  output logic [PREG_W-1:0] prs2_o_2,
  output logic [PREG_W-1:0] prd_o_2,
  output logic [PREG_W-1:0] old_prd_o_2,
  output logic [31:0]       imm_o_2,
  output logic [2:0]        alu_op_o_2,
  output logic [6:0]        opcode_o_2,
  output logic              valid_o_2,
  input  logic              free_valid_1,
  input  logic [PREG_W-1:0] free_preg_1,
  input  logic              free_valid_2,
  input  logic [PREG_W-1:0] free_preg_2
`ifdef RENAME_FREE_POOL_EN
  ,
  output logic [NUM_PREG-1:0] free_pool
`endif
);
  preg_t rat [NUM_ARCH];
  preg_t p_1, p_2;
  logic [6:0] count;
  logic need_1, need_2, xfer;
  ren_slot_t s_1, s_2, r_1, r_2;
  assign need_1 = needs_alloc(valid_1, rd_1, opcode_1);
  assign need_2 = needs_alloc(valid_2, rd_2, opcode_2);
  assign in_ready = !rst && !rs_full && count >= 7'd2;
  assign xfer = in_valid && in_ready;
  rename_free_list u_free_list (
    .clk(clk),
    .rst(rst),
    .pop_1(xfer && need_1),
    .pop_2(xfer && need_2),
    .free_valid_1(free_valid_1),
    .free_preg_1(free_preg_1),
    .free_valid_2(free_valid_2),
    .free_preg_2(free_preg_2),
    .preg_1(p_1),
    .preg_2(p_2),
    .count(count)
`ifdef RENAME_FREE_POOL_EN
    ,
    .free_pool(free_pool)
`endif
  );
  // slot 2 sees slot 1's new mapping for sources and displaced dest when slot 1 writes the same arch reg
  always_comb begin
    s_1 = '{prs1: rat[rs1_1], prs2: rat[rs2_1], prd: need_1 ? p_1 : '0, old_prd: need_1 ? rat[rd_1] : '0,
            imm: imm_1, alu_op: alu_op_1, opcode: opcode_1, valid: valid_1};
    s_2 = '{prs1: (need_1 && rs1_2 == rd_1) ? p_1 : rat[rs1_2],
            prs2: (need_1 && rs2_2 == rd_1) ? p_1 : rat[rs2_2],
            prd: need_2 ? p_2 : '0,
            old_prd: need_2 ? ((need_1 && rd_2 == rd_1) ? p_1 : rat[rd_2]) : '0,
            imm: imm_2, alu_op: alu_op_2, opcode: opcode_2, valid: valid_2};
  end
  // RAT: identity after reset; slot 2 write lands last so it wins on a shared rd; x0 is never written
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH; i++) rat[i] <= PREG_W'(i);
    end else begin
      if (xfer && need_1) rat[rd_1] <= p_1;
      if (xfer && need_2) rat[rd_2] <= p_2;
    end
  end
  // output register: captures the renamed bundle on transfer, out_valid pulses for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      r_1 <= '0;
      r_2 <= '0;
    end else begin
      out_valid <= xfer;
      if (xfer) begin
        r_1 <= s_1;
        r_2 <= s_2;
      end
    end
  end
  assign {prs1_o_1, prs2_o_1, prd_o_1, old_prd_o_1, imm_o_1, alu_op_o_1, opcode_o_1, valid_o_1} = r_1;
  assign {prs1_o_2, prs2_o_2, prd_o_2, old_prd_o_2, imm_o_2, alu_op_o_2, opcode_o_2, valid_o_2} = r_2;
endmodule

// File: tb/tb_rename_stage.sv
// tb_rename_stage: directed and randomized checks of rename_stage against a sequential-rename reference model
module tb_rename_stage;
  import ooo_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, in_valid, rs_full, in_ready, out_valid;
  logic [4:0] rs1 [1:2], rs2 [1:2], rd [1:2];
  logic [31:0] imm [1:2];
  logic [2:0] aop [1:2];
  logic [6:0] opc [1:2];
  logic vld [1:2], fv [1:2];
  logic [5:0] fp [1:2];
  logic [5:0] prs1_o [1:2], prs2_o [1:2], prd_o [1:2], old_o [1:2];
  logic [31:0] imm_o [1:2];
  logic [2:0] aop_o [1:2];
  logic [6:0] opc_o [1:2];
  logic vo [1:2];
`ifdef RENAME_FREE_POOL_EN
  logic [63:0] free_pool;
`endif
  rename_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_1(rs1[1]), .rs2_1(rs2[1]), .rd_1(rd[1]), .imm_1(imm[1]), .alu_op_1(aop[1]), .opcode_1(opc[1]), .valid_1(vld[1]),
    .rs1_2(rs1[2]), .rs2_2(rs2[2]), .rd_2(rd[2]), .imm_2(imm[2]), .alu_op_2(aop[2]), .opcode_2(opc[2]), .valid_2(vld[2]),
    .rs_full(rs_full), .out_valid(out_valid),
    .prs1_o_1(prs1_o[1]), .prs2_o_1(prs2_o[1]), .prd_o_1(prd_o[1]), .old_prd_o_1(old_o[1]),
    .imm_o_1(imm_o[1]), .alu_op_o_1(aop_o[1]), .opcode_o_1(opc_o[1]), .valid_o_1(vo[1]),
    .prs1_o_2(prs1_o[2]), .prs2_o_2(prs2_o[2]), .prd_o_2(prd_o[2]), .old_prd_o_2(old_o[2]),
    .imm_o_2(imm_o[2]), .alu_op_o_2(aop_o[2]), .opcode_o_2(opc_o[2]), .valid_o_2(vo[2]),
    .free_valid_1(fv[1]), .free_preg_1(fp[1]), .free_valid_2(fv[2]), .free_preg_2(fp[2])
`ifdef RENAME_FREE_POOL_EN
    , .free_pool(free_pool)
`endif
  );
  logic [6:0] ops [4] = '{OP_R, OP_I, OP_LOAD, OP_STORE};
  logic [5:0] rat_m [32];
  logic [5:0] fl [$];
  bit issued [64];
  logic exp_ready, obs_ready, exp_ov;
  logic [5:0] e_prs1 [1:2], e_prs2 [1:2], e_prd [1:2], e_old [1:2];
  logic [31:0] e_imm [1:2];
  logic [2:0] e_aop [1:2];
  logic [6:0] e_opc [1:2];
  logic e_vld [1:2];
  int checks = 0, errors = 0;
  task automatic idle();
    in_valid = 0; rs_full = 0;
    for (int n = 1; n <= 2; n++) begin
      vld[n] = 0; fv[n] = 0; fp[n] = 0; rs1[n] = 0; rs2[n] = 0; rd[n] = 0; imm[n] = 0; aop[n] = 0; opc[n] = OP_R;
    end
  endtask
  task automatic set_slot(input int n, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d, input logic [6:0] op, input logic v);
    rs1[n] = a; rs2[n] = b; rd[n] = d; opc[n] = op; vld[n] = v; imm[n] = $urandom; aop[n] = 3'($urandom);
  endtask
  task automatic rand_slot(input int n, input bit alloc);
    rs1[n] = 5'($urandom); rs2[n] = 5'($urandom); imm[n] = $urandom; aop[n] = 3'($urandom);
    if (alloc) begin
      vld[n] = 1; rd[n] = 5'($urandom_range(31, 1)); opc[n] = ops[$urandom_range(2, 0)];
    end else begin
      vld[n] = $urandom_range(3, 0) != 0; rd[n] = 5'($urandom); opc[n] = ops[$urandom_range(3, 0)];
    end
  endtask
  // reference: rename slots one after another against an array RAT and a queue free list, then append frees
  task automatic cycle();
    #1;
    obs_ready = in_ready;
    if (rst) begin
      for (int i = 0; i < 32; i++) rat_m[i] = 6'(i);
      fl.delete();
      for (int i = 32; i < 64; i++) fl.push_back(6'(i));
      for (int i = 0; i < 64; i++) issued[i] = i < 32;
      exp_ready = 0; exp_ov = 0;
    end else begin
      exp_ready = !rs_full && fl.size() >= 2;
      exp_ov = in_valid && exp_ready;
      if (exp_ov) for (int n = 1; n <= 2; n++) begin
        e_prs1[n] = rat_m[rs1[n]]; e_prs2[n] = rat_m[rs2[n]];
        e_imm[n] = imm[n]; e_aop[n] = aop[n]; e_opc[n] = opc[n]; e_vld[n] = vld[n];
        if (vld[n] && rd[n] != 0 && opc[n] != OP_STORE) begin
          e_old[n] = rat_m[rd[n]]; e_prd[n] = fl.pop_front(); rat_m[rd[n]] = e_prd[n];
        end else begin
          e_old[n] = 0; e_prd[n] = 0;
        end
      end
      for (int n = 1; n <= 2; n++) if (fv[n] && fp[n] != 0 && fl.size() < 64) fl.push_back(fp[n]);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    idle(); rst = 1; cycle(); rst = 0;
  endtask
  task automatic test_reset();
    rst = 1; in_valid = 1; rand_slot(1, 1); rand_slot(2, 1); fv[1] = 1; fp[1] = 6'd40;
    cycle();
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", obs_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    cycle();
    rst = 0; idle();
    for (int n = 1; n <= 2; n++) begin
      checks++;
      if ({prs1_o[n], prs2_o[n], prd_o[n], old_o[n], imm_o[n], aop_o[n], opc_o[n], vo[n]} !== '0) begin
        errors++; $display("FAIL reset_outputs slot%0d got prd %0d old %0d imm %0h exp all zero", n, prd_o[n], old_o[n], imm_o[n]);
      end
    end
    cycle();
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b exp 1", obs_ready); end
  endtask
  task automatic test_basic();
    set_slot(1, 5'd1, 5'd2, 5'd5, OP_R, 1); set_slot(2, 5'd5, 5'd0, 5'd6, OP_I, 1); in_valid = 1;
    cycle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %b exp 1", out_valid); end
    checks++; if (prd_o[1] !== 6'd32 || prd_o[2] !== 6'd33) begin errors++; $display("FAIL basic_prd got %0d,%0d exp 32,33", prd_o[1], prd_o[2]); end
    checks++; if (old_o[1] !== 6'd5 || old_o[2] !== 6'd6) begin errors++; $display("FAIL basic_old got %0d,%0d exp 5,6", old_o[1], old_o[2]); end
    checks++; if (prs1_o[2] !== 6'd32) begin errors++; $display("FAIL basic_bypass got %0d exp 32", prs1_o[2]); end
    checks++; if (prs1_o[1] !== 6'd1 || prs2_o[1] !== 6'd2 || prs2_o[2] !== 6'd0) begin errors++; $display("FAIL basic_src got %0d,%0d,%0d exp 1,2,0", prs1_o[1], prs2_o[1], prs2_o[2]); end
    checks++; if (imm_o[2] !== e_imm[2] || opc_o[2] !== OP_I) begin errors++; $display("FAIL basic_payload got %0h,%0h exp %0h,%0h", imm_o[2], opc_o[2], e_imm[2], OP_I); end
    idle(); cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse got %b exp 0", out_valid); end
  endtask
  task automatic test_same_rd();
    do_reset();
    set_slot(1, 5'd1, 5'd2, 5'd7, OP_R, 1); set_slot(2, 5'd3, 5'd4, 5'd7, OP_LOAD, 1); in_valid = 1;
    cycle();
    checks++; if (prd_o[1] !== 6'd32 || prd_o[2] !== 6'd33) begin errors++; $display("FAIL same_rd_prd got %0d,%0d exp 32,33", prd_o[1], prd_o[2]); end
    checks++; if (old_o[1] !== 6'd7 || old_o[2] !== 6'd32) begin errors++; $display("FAIL same_rd_old got %0d,%0d exp 7,32", old_o[1], old_o[2]); end
    set_slot(1, 5'd7, 5'd0, 5'd0, OP_R, 1); set_slot(2, 5'd7, 5'd7, 5'd9, OP_R, 0);
    cycle();
    checks++; if (prs1_o[1] !== 6'd33) begin errors++; $display("FAIL same_rd_read got %0d exp 33", prs1_o[1]); end
    checks++; if (prd_o[1] !== 6'd0 || prd_o[2] !== 6'd0 || vo[2] !== 1'b0) begin errors++; $display("FAIL same_rd_noalloc got %0d,%0d,%b exp 0,0,0", prd_o[1], prd_o[2], vo[2]); end
  endtask
  task automatic test_exhaust();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      rand_slot(1, 1); rand_slot(2, 1); in_valid = 1;
      cycle();
      checks++; if (obs_ready !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL exhaust_accept%0d got %b,%b exp 1,1", k, obs_ready, out_valid); end
    end
    fv[1] = 1; fp[1] = 6'd40;
    cycle();
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL exhaust_empty got %b exp 0", obs_ready); end
    fv[1] = 0;
    cycle();
    checks++; if (obs_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL exhaust_one got %b,%b exp 0,0", obs_ready, out_valid); end
    in_valid = 0; fv[1] = 1; fp[1] = 6'd41;
    cycle();
    fv[1] = 0;
    cycle();
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL exhaust_two got %b exp 1", obs_ready); end
  endtask
  task automatic test_store_x0();
    do_reset();
    set_slot(1, 5'd1, 5'd2, 5'd3, OP_STORE, 1); set_slot(2, 5'd4, 5'd5, 5'd0, OP_R, 1); in_valid = 1;
    cycle();
    checks++; if (prd_o[1] !== 6'd0 || prd_o[2] !== 6'd0 || old_o[1] !== 6'd0 || old_o[2] !== 6'd0) begin errors++; $display("FAIL store_x0 got prd %0d,%0d old %0d,%0d exp 0", prd_o[1], prd_o[2], old_o[1], old_o[2]); end
    checks++; if (vo[1] !== 1'b1 || vo[2] !== 1'b1) begin errors++; $display("FAIL store_x0_valid got %b,%b exp 1,1", vo[1], vo[2]); end
    set_slot(1, 5'd3, 5'd3, 5'd4, OP_LOAD, 1); set_slot(2, 5'd1, 5'd1, 5'd9, OP_R, 0);
    cycle();
    checks++; if (prd_o[1] !== 6'd32 || prd_o[2] !== 6'd0 || vo[2] !== 1'b0) begin errors++; $display("FAIL store_x0_next got %0d,%0d,%b exp 32,0,0", prd_o[1], prd_o[2], vo[2]); end
  endtask
  task automatic test_rs_full();
    set_slot(1, 5'd4, 5'd1, 5'd10, OP_R, 1); set_slot(2, 5'd10, 5'd4, 5'd11, OP_I, 1); in_valid = 1; rs_full = 1;
    cycle();
    checks++; if (obs_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rs_full_stall got %b,%b exp 0,0", obs_ready, out_valid); end
    rs_full = 0;
    cycle();
    checks++; if (obs_ready !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL rs_full_release got %b,%b exp 1,1", obs_ready, out_valid); end
    checks++; if (prd_o[1] !== 6'd33 || prd_o[2] !== 6'd34 || prs1_o[1] !== 6'd32 || prs1_o[2] !== 6'd33) begin errors++; $display("FAIL rs_full_rename got prd %0d,%0d prs1 %0d,%0d exp 33,34,32,33", prd_o[1], prd_o[2], prs1_o[1], prs1_o[2]); end
    idle();
  endtask
  task automatic test_wrap();
    logic [5:0] pf [1:2];
    do_reset();
    pf[1] = 0; pf[2] = 0;
    for (int k = 0; k < 100; k++) begin
      for (int n = 1; n <= 2; n++) begin rand_slot(n, 1); fv[n] = k > 0; fp[n] = pf[n]; end
      in_valid = 1;
      cycle();
      checks++; if (obs_ready !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL wrap_accept%0d got %b,%b exp 1,1", k, obs_ready, out_valid); end
      for (int n = 1; n <= 2; n++) begin
        checks++;
        if (prd_o[n] !== e_prd[n] || issued[prd_o[n]]) begin errors++; $display("FAIL wrap_prd%0d slot%0d got %0d exp %0d dup %0d", k, n, prd_o[n], e_prd[n], issued[prd_o[n]]); end
        issued[prd_o[n]] = 1;
      end
      for (int n = 1; n <= 2; n++) begin
        if (fv[n]) issued[fp[n]] = 0;
        pf[n] = e_old[n];
      end
    end
    idle(); cycle();
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL wrap_end_ready got %b exp 1", obs_ready); end
  endtask
  task automatic test_random();
    logic [5:0] dead [$];
    do_reset();
    for (int k = 0; k < 300; k++) begin
      rand_slot(1, 0); rand_slot(2, 0);
      in_valid = $urandom_range(3, 0) != 0; rs_full = $urandom_range(3, 0) == 0;
      for (int n = 1; n <= 2; n++) begin
        fv[n] = dead.size() > 0 && $urandom_range(1, 0) == 1;
        fp[n] = fv[n] ? dead.pop_front() : 6'd0;
      end
      cycle();
      checks++; if (obs_ready !== exp_ready || out_valid !== exp_ov) begin errors++; $display("FAIL rand_hs%0d got %b,%b exp %b,%b", k, obs_ready, out_valid, exp_ready, exp_ov); end
      if (exp_ov) for (int n = 1; n <= 2; n++) begin
        checks++;
        if ({prs1_o[n], prs2_o[n], prd_o[n], old_o[n]} !== {e_prs1[n], e_prs2[n], e_prd[n], e_old[n]}) begin
          errors++; $display("FAIL rand_regs%0d slot%0d got %0d,%0d,%0d,%0d exp %0d,%0d,%0d,%0d", k, n, prs1_o[n], prs2_o[n], prd_o[n], old_o[n], e_prs1[n], e_prs2[n], e_prd[n], e_old[n]);
        end
        checks++;
        if ({imm_o[n], aop_o[n], opc_o[n], vo[n]} !== {e_imm[n], e_aop[n], e_opc[n], e_vld[n]}) begin
          errors++; $display("FAIL rand_payload%0d slot%0d got %0h,%0d,%0h,%b exp %0h,%0d,%0h,%b", k, n, imm_o[n], aop_o[n], opc_o[n], vo[n], e_imm[n], e_aop[n], e_opc[n], e_vld[n]);
        end
        if (e_prd[n] != 0) dead.push_back(e_old[n]);
      end
    end
    idle(); cycle();
  endtask
  initial begin
    idle(); rst = 1;
    test_reset();
    test_basic();
    test_same_rd();
    test_exhaust();
    test_store_x0();
    test_rs_full();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
